qmult_iter: RTL

Iterative signed-magnitude fixed-point multiplier, parametrised successor to the team's bit-serial shift-add multiplier. Numbers are N bits: bit N-1 is the sign, bits N-2:0 are the magnitude, and the low Q bits are fractional. Each cycle consumes BPC multiplier bits, trading latency against adder width. Adds a ready/valid handshake, optional round-half-up, optional saturation and negative-zero suppression. Sits beside the other q-format arithmetic blocks in datapaths that cannot afford a single-cycle multiplier.

---
 rtl/qmult_iter_if.sv | 28 ++
 rtl/qmult_iter.sv | 110 +++++++++++
 2 files changed

// File: rtl/qmult_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : qmult_iter_if
// Brief    : Operand/result handshake bundle for the iterative q-format multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface qmult_iter_if #(
    parameter int N = 32
) ();
    logic [N-1:0] i_multiplicand;
    logic [N-1:0] i_multiplier;
    logic         i_start;
    logic         o_ready;
    logic         o_valid;
    logic [N-1:0] o_result_out;
    logic         o_overflow;

    modport master (
        output i_multiplicand, i_multiplier, i_start,
        input  o_ready, o_valid, o_result_out, o_overflow
    );

    modport slave (
        input  i_multiplicand, i_multiplier, i_start,
        output o_ready, o_valid, o_result_out, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/qmult_iter.sv
`default_nettype none
// ============================================================================
// Module   : qmult_iter
// Brief    : Iterative signed-magnitude fixed-point multiplier, BPC bits/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module qmult_iter #(
    parameter int Q     = 15,
    parameter int N     = 32,
    parameter int BPC   = 1,
    parameter int ROUND = 0,
    parameter int SAT   = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    qmult_iter_if.slave  bus
);
    localparam int c_ITER = (N - 1 + BPC - 1) / BPC;
    localparam int c_CW   = $clog2(c_ITER + 1);
    localparam int c_AW   = 2 * N - 2;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_ITER - 1);
    localparam logic [c_AW:0]   c_RND  = (ROUND != 0) ? ({{c_AW{1'b0}}, 1'b1} << (Q - 1))
                                                      : {(c_AW + 1){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_AW-1:0] r_acc;
    logic [c_AW-1:0] r_mag_a;
    logic [N-2:0]    r_mag_b;
    logic            r_sign;
    logic [c_CW-1:0] r_cnt;
    logic            r_valid;
    logic [N-1:0]    r_result;
    logic            r_ovf;

    logic [c_AW-1:0] w_partial;
    logic [c_AW:0]   w_p;
    logic            w_ovf;
    logic [N-2:0]    w_mag;
    logic            w_unused_lsb;

    // Multiplicand is pre-shifted each cycle, so the partial product needs no barrel shifter.
    assign w_partial    = r_mag_a * c_AW'(r_mag_b[BPC-1:0]);
    assign w_p          = {1'b0, r_acc} + c_RND;
    assign w_ovf        = |w_p[c_AW:N-1+Q];
    assign w_mag        = ((SAT != 0) && w_ovf) ? {(N-1){1'b1}} : w_p[N-2+Q:Q];
    assign w_unused_lsb = ^w_p[Q-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_mag_a <= {{(N-1){1'b0}}, bus.i_multiplicand[N-2:0]};
                        r_mag_b <= bus.i_multiplier[N-2:0];
                        r_sign  <= bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= r_acc + w_partial;
                    r_mag_a <= r_mag_a << BPC;
                    r_mag_b <= r_mag_b >> BPC;
                    r_cnt   <= r_cnt + c_CW'(1);
                end
                S_DONE: begin
                    // A zero magnitude never carries a sign bit.
                    r_result <= {r_sign && (w_mag != '0), w_mag};
                    r_ovf    <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready      = (r_state == S_IDLE);
    assign bus.o_valid      = r_valid;
    assign bus.o_result_out = r_result;
    assign bus.o_overflow   = r_ovf;
endmodule
`default_nettype wire
